l1_miss_requester: RTL

L1-side miss service engine that initiates transactions to the L2 cache over the mem_read/mem_write/mem_resp handshake. On an L1 miss it writes back a dirty victim line if there is one, then fetches the missing line. It returns the fill line to the L1 datapath with a one-cycle done pulse. It sits between the L1 cache control FSM and the L2 cache's CPU-facing port.

---
 rtl/l1_miss_requester.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/l1_miss_requester.sv
// L1 miss service engine: optional dirty-victim writeback, then line fill from L2.
// Optional L2 watchdog compiled in with `define L1_MISS_WATCHDOG_EN.
module l1_miss_requester #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [LINE_W-1:0] victim_data,
  output logic              miss_done,
  output logic [LINE_W-1:0] fill_data,
  output logic              busy,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata,
  output logic              l2_timeout
);

  localparam int unsigned OFFSET_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_GAP,
    S_FILL,
    S_DONE
  } state_t;

  state_t            state_q, state_nx;
  logic [ADDR_W-1:0] miss_line_q, miss_line_nx;
  logic [ADDR_W-1:0] victim_line_q, victim_line_nx;
  logic [LINE_W-1:0] victim_data_q, victim_data_nx;
  logic [LINE_W-1:0] fill_nx;

  logic              miss_done_nx;
  logic              busy_nx;
  logic              l2_read_nx;
  logic              l2_write_nx;
  logic [ADDR_W-1:0] l2_address_nx;
  logic [LINE_W-1:0] l2_wdata_nx;

  // Next state, capture and next-output decode; outputs are then registered
  // so every output reflects the state it belongs to with no path from l2_resp.
  always_comb begin
    state_nx       = state_q;
    miss_line_nx   = miss_line_q;
    victim_line_nx = victim_line_q;
    victim_data_nx = victim_data_q;
    fill_nx        = fill_data;

    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          miss_line_nx   = miss_addr & ~OFFSET_MASK;
          victim_line_nx = victim_addr & ~OFFSET_MASK;
          victim_data_nx = victim_data;
          state_nx       = victim_dirty ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (l2_resp) state_nx = S_GAP;
      end
      S_GAP: begin
        state_nx = S_FILL;
      end
      S_FILL: begin
        if (l2_resp) begin
          fill_nx  = l2_rdata;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    miss_done_nx  = (state_nx == S_DONE);
    busy_nx       = (state_nx != S_IDLE);
    l2_write_nx   = (state_nx == S_WB);
    l2_read_nx    = (state_nx == S_FILL);
    l2_address_nx = '0;
    l2_wdata_nx   = '0;
    if (state_nx == S_WB) begin
      l2_address_nx = victim_line_nx;
      l2_wdata_nx   = victim_data_nx;
    end else if (state_nx == S_FILL) begin
      l2_address_nx = miss_line_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      miss_line_q   <= '0;
      victim_line_q <= '0;
      victim_data_q <= '0;
      fill_data     <= '0;
      miss_done     <= 1'b0;
      busy          <= 1'b0;
      l2_read       <= 1'b0;
      l2_write      <= 1'b0;
      l2_address    <= '0;
      l2_wdata      <= '0;
    end else begin
      state_q       <= state_nx;
      miss_line_q   <= miss_line_nx;
      victim_line_q <= victim_line_nx;
      victim_data_q <= victim_data_nx;
      fill_data     <= fill_nx;
      miss_done     <= miss_done_nx;
      busy          <= busy_nx;
      l2_read       <= l2_read_nx;
      l2_write      <= l2_write_nx;
      l2_address    <= l2_address_nx;
      l2_wdata      <= l2_wdata_nx;
    end
  end

`ifdef L1_MISS_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

  logic [WDOG_W-1:0] wdog_cnt_q;
  logic              timeout_q;
  logic              waiting;
  logic              entering;

  assign waiting  = (state_q == S_WB) || (state_q == S_FILL);
  assign entering = (state_nx != state_q) && ((state_nx == S_WB) || (state_nx == S_FILL));

  // Counts unanswered cycles of the current request; flag is sticky and never aborts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (entering) begin
        wdog_cnt_q <= '0;
      end else if (waiting && !l2_resp && (wdog_cnt_q != WDOG_W'(WDOG_LIMIT))) begin
        wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
      end
      if (waiting && !l2_resp && (wdog_cnt_q == WDOG_W'(WDOG_LIMIT - 1))) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign l2_timeout = timeout_q;
`else
  assign l2_timeout = 1'b0;
`endif

endmodule
